// File: rtl/alu_pkg.sv
// Shared types, constants and CRC helper for the serial ALU command front-end.
// CRC checking in the top is built only when ALU_RX_CRC_EN is defined.
package alu_pkg;

    localparam int         FRAME_BITS  = 11;
    localparam int         DATA_BITS   = FRAME_BITS - 3;
    localparam int         DATA_FRAMES = 8;
    localparam logic [3:0] CRC_POLY    = 4'h3;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } alu_op_t;

    typedef enum logic {
        PKT_DATA = 1'b0,
        PKT_CTL  = 1'b1
    } packet_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_TYPE,
        FR_DATA,
        FR_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        CMD_COLLECT,
        CMD_CHECK,
        CMD_HOLD
    } cmd_state_t;

    // Bit-serial CRC4, MSB first, initial value 0.
    function automatic logic [3:0] crc4_calc(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'h0);
        end
        return c;
    endfunction

    function automatic logic op_supported(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/alu_rx_frame.sv
// Single-frame receiver: start | type | d[7:0] | stop, one bit per clock.
// Pulses o_frame_done for one cycle after the stop bit has been sampled.
module alu_rx_frame
    import alu_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sin,
    output logic       o_frame_done,
    output packet_t    o_frame_type,
    output logic [7:0] o_frame_byte,
    output logic       o_stop_err
);

    frame_state_t r_state;
    frame_state_t w_next_state;
    logic [2:0]   r_bit_cnt;
    logic [7:0]   r_shift;
    packet_t      r_type;
    logic         r_done;
    logic         r_stop_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FR_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FR_IDLE: if (!i_sin) w_next_state = FR_TYPE;
            FR_TYPE: w_next_state = FR_DATA;
            FR_DATA: if (r_bit_cnt == 3'(DATA_BITS - 1)) w_next_state = FR_STOP;
            FR_STOP: w_next_state = FR_IDLE;
            default: w_next_state = FR_IDLE;
        endcase
    end

    // Byte and type stay stable from the stop bit until the next frame's data phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_type     <= PKT_DATA;
            r_done     <= 1'b0;
            r_stop_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                FR_TYPE: begin
                    r_type    <= packet_t'(i_sin);
                    r_bit_cnt <= 3'd0;
                end
                FR_DATA: begin
                    r_shift   <= {r_shift[6:0], i_sin};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                FR_STOP: begin
                    r_done     <= 1'b1;
                    r_stop_err <= ~i_sin;
                end
                default: ;
            endcase
        end
    end

    assign o_frame_done = r_done;
    assign o_frame_type = r_type;
    assign o_frame_byte = r_shift;
    assign o_stop_err   = r_stop_err;

endmodule

// File: rtl/alu_serial_rx.sv
// Serial ALU command front-end: assembles {B,A,op,crc4} frames, checks them, and
// presents one command per handshake. CRC checking built only with ALU_RX_CRC_EN.
module alu_serial_rx
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    output logic [2:0]  cmd_op,
    output logic        err_data,
    output logic        err_crc,
    output logic        err_op
);

    localparam logic [3:0] CNT_FULL = 4'(DATA_FRAMES);
    localparam logic [3:0] CNT_SAT  = 4'(DATA_FRAMES + 1);

    logic       w_frame_done;
    packet_t    w_frame_type;
    logic [7:0] w_frame_byte;
    logic       w_stop_err;

    alu_rx_frame u_frame (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sin        (sin),
        .o_frame_done (w_frame_done),
        .o_frame_type (w_frame_type),
        .o_frame_byte (w_frame_byte),
        .o_stop_err   (w_stop_err)
    );

    cmd_state_t  r_state;
    cmd_state_t  w_next_state;
    logic [63:0] r_shift;
    logic [3:0]  r_data_cnt;
    logic        r_bad_frame;
    logic        r_len_err;
    logic [2:0]  r_op;
    logic        w_data_ok;
    logic        w_ctl_ok;
    logic        w_crc_err;
    logic        w_op_err;
    logic        w_unused_bits;

    logic        r_cmd_valid;
    logic [31:0] r_cmd_a;
    logic [31:0] r_cmd_b;
    logic [2:0]  r_cmd_op;
    logic        r_err_data;
    logic        r_err_crc;
    logic        r_err_op;

    assign w_data_ok = w_frame_done && !w_stop_err && (w_frame_type == PKT_DATA);
    assign w_ctl_ok  = w_frame_done && !w_stop_err && (w_frame_type == PKT_CTL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CMD_COLLECT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake: cmd_valid stays high with all outputs frozen until a cycle with
    // cmd_valid && cmd_ready; that edge is the transfer and cmd_valid drops after it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CMD_COLLECT: if (w_ctl_ok) w_next_state = CMD_CHECK;
            CMD_CHECK:   w_next_state = CMD_HOLD;
            CMD_HOLD:    if (r_cmd_valid && cmd_ready) w_next_state = CMD_COLLECT;
            default:     w_next_state = CMD_COLLECT;
        endcase
    end

    // Data frames arriving while a command is held are an overrun and poison the
    // frame count until the next ctl frame, which is itself dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 64'h0;
            r_data_cnt  <= 4'd0;
            r_bad_frame <= 1'b0;
            r_len_err   <= 1'b0;
            r_op        <= 3'b000;
        end else if (w_frame_done) begin
            if (w_stop_err) begin
                r_bad_frame <= 1'b1;
            end else if (w_data_ok) begin
                if (r_state == CMD_COLLECT) begin
                    r_shift <= {r_shift[55:0], w_frame_byte};
                    if (r_data_cnt != CNT_SAT) r_data_cnt <= r_data_cnt + 4'd1;
                end else begin
                    r_bad_frame <= 1'b1;
                end
            end else begin
                r_data_cnt  <= 4'd0;
                r_bad_frame <= 1'b0;
                if (r_state == CMD_COLLECT) begin
                    r_len_err <= (r_data_cnt != CNT_FULL) || r_bad_frame;
                    r_op      <= w_frame_byte[6:4];
                end
            end
        end
    end

`ifdef ALU_RX_CRC_EN
    logic [3:0] r_crc_rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_rx <= 4'h0;
        end else if (w_ctl_ok && (r_state == CMD_COLLECT)) begin
            r_crc_rx <= w_frame_byte[3:0];
        end
    end

    assign w_crc_err     = (crc4_calc({r_shift, 1'b1, r_op}) != r_crc_rx);
    assign w_unused_bits = w_frame_byte[7];
`else
    assign w_crc_err     = 1'b0;
    assign w_unused_bits = ^{w_frame_byte[7], w_frame_byte[3:0]};
`endif

    assign w_op_err = !op_supported(r_op);

    // Errors are exclusive with priority data > crc > op; payload is zero on any error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_a     <= 32'h0;
            r_cmd_b     <= 32'h0;
            r_cmd_op    <= 3'b000;
            r_err_data  <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_op    <= 1'b0;
        end else begin
            case (r_state)
                CMD_CHECK: begin
                    r_cmd_valid <= 1'b1;
                    r_err_data  <= r_len_err;
                    r_err_crc   <= !r_len_err && w_crc_err;
                    r_err_op    <= !r_len_err && !w_crc_err && w_op_err;
                    if (!r_len_err && !w_crc_err && !w_op_err) begin
                        r_cmd_a  <= r_shift[31:0];
                        r_cmd_b  <= r_shift[63:32];
                        r_cmd_op <= r_op;
                    end else begin
                        r_cmd_a  <= 32'h0;
                        r_cmd_b  <= 32'h0;
                        r_cmd_op <= 3'b000;
                    end
                end
                CMD_HOLD: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_a     <= 32'h0;
                        r_cmd_b     <= 32'h0;
                        r_cmd_op    <= 3'b000;
                        r_err_data  <= 1'b0;
                        r_err_crc   <= 1'b0;
                        r_err_op    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_a     = r_cmd_a;
    assign cmd_b     = r_cmd_b;
    assign cmd_op    = r_cmd_op;
    assign err_data  = r_err_data;
    assign err_crc   = r_err_crc;
    assign err_op    = r_err_op;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Bench for alu_serial_rx: directed scenarios plus randomized commands against a
// frame-level reference model; follows ALU_RX_CRC_EN the same way the design does.
`timescale 1ns/1ps
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sin;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [2:0]  cmd_op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          n_unstable = 0;
    logic        hold_watch = 1'b0;
    logic [70:0] hold_snap;
    logic [69:0] exp_q[$];

    always #5 clk = ~clk;

    alu_serial_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sin       (sin),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .err_data  (err_data),
        .err_crc   (err_crc),
        .err_op    (err_op)
    );

    task automatic check_eq(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference CRC: remainder of msg(x)*x^4 divided by x^4+x+1 (long division).
    function automatic logic [3:0] ref_crc(input logic [67:0] msg);
        logic [71:0] r;
        r = {msg, 4'h0};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    // Expected {err_data, err_crc, err_op, op, b, a} for one command.
    function automatic logic [69:0] ref_expect(input logic [31:0] b, input logic [31:0] a,
                                               input logic [2:0] op, input logic [3:0] crc,
                                               input int nframes, input int bad_idx);
        if (bad_idx >= 0 || nframes != 8) return {3'b100, 67'd0};
`ifdef ALU_RX_CRC_EN
        if (ref_crc({b, a, 1'b1, op}) != crc) return {3'b010, 67'd0};
`endif
        if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return {3'b001, 67'd0};
        return {3'b000, op, b, a};
    endfunction

    function automatic logic [69:0] observed();
        return {err_data, err_crc, err_op, cmd_op, cmd_b, cmd_a};
    endfunction

    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] bits;
        bits = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            sin = bits[i];
            @(negedge clk);
        end
        sin = 1'b1;
    endtask

    task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                            input logic [3:0] crc, input int nframes, input int bad_idx);
        logic [63:0] ba;
        logic [7:0]  extra;
        logic [7:0]  d;
        int          idx;
        ba    = {b, a};
        extra = 8'($urandom);
        for (int k = 0; k < nframes; k++) begin
            idx = (nframes > 8) ? k - (nframes - 8) : k;
            d   = (idx < 0) ? extra : ba[63 - 8*idx -: 8];
            send_frame(1'b0, d, (k == bad_idx) ? 1'b0 : 1'b1);
        end
        send_frame(1'b1, {1'b0, op, crc}, 1'b1);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 70'(cmd_valid), 70'd1);
    endtask

    // Full command with latency and handshake-length checks; result checked by the monitor.
    task automatic run_cmd(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                           input logic [3:0] crc, input int nframes, input int bad_idx,
                           input int rdy_delay);
        int n;
        cmd_ready = (rdy_delay == 0);
        exp_q.push_back(ref_expect(b, a, op, crc, nframes, bad_idx));
        send_cmd(b, a, op, crc, nframes, bad_idx);
        check_eq("lat_stop", 70'(cmd_valid), 70'd0);
        @(negedge clk);
        check_eq("lat_check", 70'(cmd_valid), 70'd0);
        @(negedge clk);
        check_eq("lat_valid", 70'(cmd_valid), 70'd1);
        if (rdy_delay > 0) begin
            repeat (rdy_delay) @(negedge clk);
            cmd_ready = 1'b1;
        end
        n = 0;
        while (cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("valid_len", 70'(n), 70'd1);
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && cmd_valid && cmd_ready) begin
            check_eq("xfer_expected", 70'(exp_q.size() != 0), 70'd1);
            if (exp_q.size() != 0) check_eq("cmd_result", observed(), exp_q.pop_front());
        end
        if (hold_watch && ({cmd_valid, observed()} !== hold_snap)) n_unstable++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  crc;
        logic [63:0] ba;
        logic [10:0] bits;
        int          nfr;
        int          bad;
        int          sel;
        int          rises;

        rst_n     = 1'b0;
        sin       = 1'b1;
        cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {cmd_valid, observed()}, 70'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic ADD, ready already high.
        run_cmd(32'd2, 32'd1, 3'b100, ref_crc({32'd2, 32'd1, 1'b1, 3'b100}), 8, -1, 0);

        // SUB of all-ones with corrupted crc.
        crc = ref_crc({32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 3'b101}) ^ 4'h1;
        run_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b101, crc, 8, -1, 2);

        // Short command, then a normal one.
        run_cmd(32'h1234_5678, 32'h9ABC_DEF0, 3'b000,
                ref_crc({32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 3'b000}), 7, -1, 0);
        run_cmd(32'hCAFE_0001, 32'h0BAD_F00D, 3'b001,
                ref_crc({32'hCAFE_0001, 32'h0BAD_F00D, 1'b1, 3'b001}), 8, -1, 0);

        // Unsupported opcode with good crc; valid opcode with bad crc.
        run_cmd(32'h0000_00FF, 32'h0000_0F0F, 3'b010,
                ref_crc({32'h0000_00FF, 32'h0000_0F0F, 1'b1, 3'b010}), 8, -1, 1);
        crc = ref_crc({32'h5555_AAAA, 32'h0F0F_F0F0, 1'b1, 3'b100}) ^ 4'h6;
        run_cmd(32'h5555_AAAA, 32'h0F0F_F0F0, 3'b100, crc, 8, -1, 0);

        // Bad stop bit in a data frame, and an over-long command.
        run_cmd(32'h1111_2222, 32'h3333_4444, 3'b100,
                ref_crc({32'h1111_2222, 32'h3333_4444, 1'b1, 3'b100}), 8, 3, 0);
        run_cmd(32'h7777_8888, 32'h9999_AAAA, 3'b101,
                ref_crc({32'h7777_8888, 32'h9999_AAAA, 1'b1, 3'b101}), 9, -1, 0);

        // Hold with ready low while a second command arrives and is dropped.
        cmd_ready = 1'b0;
        exp_q.push_back(ref_expect(32'hDEAD_BEEF, 32'h0000_0042, 3'b000,
                                   ref_crc({32'hDEAD_BEEF, 32'h0000_0042, 1'b1, 3'b000}), 8, -1));
        send_cmd(32'hDEAD_BEEF, 32'h0000_0042, 3'b000,
                 ref_crc({32'hDEAD_BEEF, 32'h0000_0042, 1'b1, 3'b000}), 8, -1);
        wait_valid("hold_valid");
        hold_snap  = {cmd_valid, observed()};
        n_unstable = 0;
        hold_watch = 1'b1;
        send_cmd(32'h0101_0101, 32'h0202_0202, 3'b100,
                 ref_crc({32'h0101_0101, 32'h0202_0202, 1'b1, 3'b100}), 8, -1);
        repeat (5) @(negedge clk);
        hold_watch = 1'b0;
        check_eq("hold_stable", 70'(n_unstable), 70'd0);
        check_eq("hold_pending", 70'(exp_q.size()), 70'd1);
        cmd_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_drop", 70'(cmd_valid), 70'd0);
        rises = 0;
        repeat (30) begin
            @(negedge clk);
            if (cmd_valid) rises++;
        end
        check_eq("overrun_dropped", 70'(rises), 70'd0);

        // Reset mid-frame (data frame 4, bit 5) while a command is held.
        cmd_ready = 1'b0;
        exp_q.push_back(ref_expect(32'hA5A5_5A5A, 32'h1357_9BDF, 3'b101,
                                   ref_crc({32'hA5A5_5A5A, 32'h1357_9BDF, 1'b1, 3'b101}), 8, -1));
        send_cmd(32'hA5A5_5A5A, 32'h1357_9BDF, 3'b101,
                 ref_crc({32'hA5A5_5A5A, 32'h1357_9BDF, 1'b1, 3'b101}), 8, -1);
        wait_valid("pre_reset_valid");
        ba = {32'h2468_ACE0, 32'hFDB9_7531};
        for (int k = 0; k < 4; k++) send_frame(1'b0, ba[63 - 8*k -: 8], 1'b1);
        bits = {1'b0, 1'b0, ba[31:24], 1'b1};
        for (int i = 10; i >= 6; i--) begin
            sin = bits[i];
            @(negedge clk);
        end
        rst_n = 1'b0;
        sin   = 1'b1;
        #2;
        check_eq("reset_mid_frame", {cmd_valid, observed()}, 70'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_release", {cmd_valid, observed()}, 70'd0);
        run_cmd(32'h2468_ACE0, 32'hFDB9_7531, 3'b100,
                ref_crc({32'h2468_ACE0, 32'hFDB9_7531, 1'b1, 3'b100}), 8, -1, 0);

        // Randomized commands.
        for (int t = 0; t < 20; t++) begin
            a   = $urandom;
            b   = $urandom;
            op  = 3'($urandom_range(0, 7));
            crc = ref_crc({b, a, 1'b1, op});
            if ($urandom_range(0, 4) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            sel = $urandom_range(0, 9);
            nfr = (sel == 0) ? 7 : (sel == 1) ? 9 : 8;
            bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, nfr - 1) : -1;
            run_cmd(b, a, op, crc, nfr, bad, $urandom_range(0, 4));
        end

        repeat (5) @(negedge clk);
        check_eq("queue_drained", 70'(exp_q.size()), 70'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
